// File: rtl/card_pkg.sv
// Shared types and constants for the card board writer and any logic that
// reads the board memory.
package card_pkg;

    localparam int DATA_W    = 5;
    localparam int ADDR_W    = 6;
    localparam int NUM_CARDS = 36;
    localparam int NUM_PAIRS = NUM_CARDS / 2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [DATA_W-1:0] card_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHUFFLE,
        S_WRITE,
        S_DONE
    } dealer_state_t;

    // Smallest all-ones value covering i: bit b is set when i reaches 2**b.
    function automatic addr_t range_mask(input addr_t i);
        addr_t m;
        m = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if ((i >> b) != '0) m[b] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// 16-bit right-shifting Galois LFSR with a synchronous seed load that takes
// the place of the advance on the load cycle.
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] INIT = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_q <= INIT;
        else if (load)
            r_q <= seed;
        else
            r_q <= (r_q >> 1) ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign q = r_q;

endmodule

// File: rtl/card_dealer.sv
// Builds a 36-card pair board, shuffles it with an LFSR-driven Fisher-Yates
// pass over a shadow array, then streams it into the card memory.
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       seed,
    output logic              wEn,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] dataIn,
    output logic              busy,
    output logic              boardReady
);

    localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(NUM_CARDS - 1);
    localparam logic [ADDR_W:0] K_END  = (ADDR_W+1)'(NUM_CARDS);
    localparam addr_t           I_TOP  = addr_t'(NUM_CARDS - 1);
    localparam addr_t           I_ONE  = addr_t'(1);

    dealer_state_t r_state, w_next;
    logic [ADDR_W:0] r_k;
    addr_t           r_i;
    card_t           r_arr [NUM_CARDS];
    logic            r_wen;
    addr_t           r_waddr;
    card_t           r_data;

    logic [15:0] w_lfsr;
    logic        w_accept;
    logic        w_load;
    addr_t       w_j;
    logic        w_take;
    addr_t       w_kaddr;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_load   = w_accept && (seed != 16'h0000);
    assign w_j      = w_lfsr[ADDR_W-1:0] & range_mask(r_i);
    assign w_take   = (w_j <= r_i);
    assign w_kaddr  = r_k[ADDR_W-1:0];

    lfsr16 #(.INIT(LFSR_INIT)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (w_load),
        .seed  (seed),
        .q     (w_lfsr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)              w_next = S_FILL;
            S_FILL:         if (r_k == K_LAST)      w_next = S_SHUFFLE;
            S_SHUFFLE:      if (w_take && r_i == I_ONE) w_next = S_WRITE;
            S_WRITE:        if (r_k == K_END)       w_next = S_DONE;
            default:                                w_next = S_IDLE;
        endcase
    end

    // Write port is registered, so WRITE runs one extra cycle to drop wEn.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_k     <= '0;
            r_i     <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) r_k <= '0;
                end
                S_FILL: begin
                    if (r_k == K_LAST) r_i <= I_TOP;
                    else               r_k <= r_k + 1'b1;
                end
                S_SHUFFLE: begin
                    if (w_take) begin
                        if (r_i == I_ONE) r_k <= '0;
                        else              r_i <= r_i - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_k == K_END) begin
                        r_wen <= 1'b0;
                    end else begin
                        r_wen   <= 1'b1;
                        r_waddr <= w_kaddr;
                        r_data  <= r_arr[w_kaddr];
                        r_k     <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow board; fully rewritten by FILL before it is read.
    always_ff @(posedge clock) begin
        if (r_state == S_FILL) begin
            r_arr[w_kaddr] <= card_t'(r_k >> 1);
        end else if (r_state == S_SHUFFLE && w_take) begin
            r_arr[r_i] <= r_arr[w_j];
            r_arr[w_j] <= r_arr[r_i];
        end
    end

    assign wEn        = r_wen;
    assign wAddr      = r_waddr;
    assign dataIn     = r_data;
    assign busy       = (r_state == S_FILL) || (r_state == S_SHUFFLE) || (r_state == S_WRITE);
    assign boardReady = (r_state == S_DONE);

endmodule
